// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared pipeline constants and fetch state encoding
package fetch_stage_pkg;

    localparam int unsigned WORD_W = 16;

    localparam logic [WORD_W-1:0] NOP_INSTR = 16'h0000;

    localparam logic [1:0] FS_RUN    = 2'd0;
    localparam logic [1:0] FS_STALL  = 2'd1;
    localparam logic [1:0] FS_HALTED = 2'd2;

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// rtl/fetch_stage_pc_reg.sv - program counter register with load/hold/increment
// Load has priority over increment; neither asserted holds the current value.
module pc_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 16'h0000,
    parameter int unsigned       PC_STEP  = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [WORD_W-1:0] load_val_i,
    input  logic              inc_i,
    output logic [WORD_W-1:0] pc_o
);

    localparam logic [WORD_W-1:0] STEP = WORD_W'(PC_STEP);

    logic [WORD_W-1:0] pc_q;
    logic [WORD_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + STEP;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, redirect, stall replay, sticky halt
// Optional FETCH_RESUME_EN adds a Resume input that leaves HALTED.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 16'h0000,
    parameter int unsigned       PC_STEP  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] ImemData,
    input  logic              BranchTaken,
    input  logic [WORD_W-1:0] BranchTarget,
    input  logic              StopPC,
    input  logic              Halt,
`ifdef FETCH_RESUME_EN
    input  logic              Resume,
`endif
    output logic [WORD_W-1:0] ImemAddr,
    output logic [WORD_W-1:0] PCOUT,
    output logic [WORD_W-1:0] InstructionOut,
    output logic [WORD_W-1:0] OldInstruction,
    output logic              FlushOut,
    output logic              StayHalted
);

    localparam logic [WORD_W-1:0] STEP = WORD_W'(PC_STEP);

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [WORD_W-1:0] old_instr_q;
    logic [WORD_W-1:0] old_instr_d;
    logic              pc_load;
    logic              pc_inc;
    logic [WORD_W-1:0] pc;

    pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .clk_i      (clk),
        .rst_ni     (rst),
        .load_i     (pc_load),
        .load_val_i (BranchTarget),
        .inc_i      (pc_inc),
        .pc_o       (pc)
    );

    always_comb begin
        state_d     = state_q;
        old_instr_d = old_instr_q;
        pc_load     = 1'b0;
        pc_inc      = 1'b0;
        if (state_q == FS_HALTED) begin
`ifdef FETCH_RESUME_EN
            if (!Halt && Resume) begin
                pc_inc  = 1'b1;
                state_d = FS_RUN;
            end
`endif
        end else if (Halt) begin
            state_d = FS_HALTED;
        end else if (BranchTaken) begin
            pc_load = 1'b1;
            state_d = FS_RUN;
        end else if (StopPC) begin
            state_d = FS_STALL;
        end else begin
            // Only a free-running RUN cycle hands a fresh instruction to IF/ID.
            if (state_q != FS_STALL) begin
                old_instr_d = ImemData;
            end
            pc_inc  = 1'b1;
            state_d = FS_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FS_RUN;
            old_instr_q <= NOP_INSTR;
        end else begin
            state_q     <= state_d;
            old_instr_q <= old_instr_d;
        end
    end

    assign ImemAddr       = pc;
    assign PCOUT          = pc + STEP;
    assign InstructionOut = ImemData;
    assign OldInstruction = old_instr_q;
    assign StayHalted     = (state_q == FS_HALTED);
    assign FlushOut       = BranchTaken & (state_q != FS_HALTED) & ~Halt;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 16-bit 5-stage pipeline, directly upstream of the IF/ID register. Owns the program counter and addresses instruction memory. Produces the instruction, return PC, flush and halt-hold signals that IF/ID latches. Handles redirect from execute, hazard stalls with instruction replay, and sticky halt.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- PC_STEP, 2, sequential PC increment (byte-addressed 16-bit instructions)
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset
- ImemData  in  16  instruction memory read data; combinational function of ImemAddr
- BranchTaken  in  1  redirect request from execute
- BranchTarget  in  16  redirect PC; valid when BranchTaken=1
- StopPC  in  1  hazard-unit stall
- Halt  in  1  halt opcode detected in decode
- Resume  in  1  leave HALTED; present only with FETCH_RESUME_EN
- ImemAddr  out  16  current PC
- PCOUT  out  16  PC + PC_STEP, to IF/ID PCIN
- InstructionOut  out  16  ImemData passthrough, to IF/ID InstructionIn
- OldInstruction  out  16  last instruction accepted by IF/ID, for stall replay
- FlushOut  out  1  to IF/ID FlushIn; kills wrong-path instruction
- StayHalted  out  1  sticky halt indication to IF/ID and later stages

## Operation
- States: RUN, STALL, HALTED (2-bit encoding).
- Per-edge priority: rst > Halt > BranchTaken > StopPC > sequential.
- Halt=1 in any state: next state HALTED, PC frozen, OldInstruction frozen.
- HALTED: PC, OldInstruction frozen; StayHalted=1; BranchTaken and StopPC ignored; exit only by reset (or Resume, see Configuration).
- BranchTaken=1 in RUN or STALL: PC <= BranchTarget, next state RUN; FlushOut=1 in the same cycle (combinational), so IF/ID captures a flushed slot.
- StopPC=1 in RUN (no branch/halt): PC held, next state STALL, OldInstruction held.
- STALL with StopPC=1: remain; PC held. StopPC=0: next state RUN, PC <= PC + PC_STEP.
- RUN, no events: PC <= PC + PC_STEP; OldInstruction <= ImemData.
- PC arithmetic modulo 2^16; 16'hFFFE + 2 wraps to 16'h0000 silently.
- BranchTarget used as-is; bit 0 not masked.
- FlushOut = BranchTaken & (state != HALTED) & ~Halt.
- StayHalted = (state == HALTED).

## Timing
- Reset (asynchronous assert): PC=RESET_PC, state=RUN, OldInstruction=16'h0000, StayHalted=0; FlushOut=0 unless BranchTaken is driven; first fetch from RESET_PC in the first cycle after deassert.
- ImemAddr, PCOUT, InstructionOut: combinational from PC and ImemData. Zero added latency; IF/ID sees the instruction at the next edge.
- Redirect latency: one edge. Instruction at BranchTarget appears on InstructionOut in the cycle after BranchTaken.
- Stall: PC unchanged on every edge with StopPC=1. Resumes the sequential fetch on the first edge after StopPC falls.
- Halt wins over a simultaneous BranchTaken: no redirect and FlushOut=0.
- Halt wins over a simultaneous StopPC.
- Reset mid-stall or mid-halt: returns immediately to the reset values above.

## Configuration
- FETCH_RESUME_EN defined:
  - Resume port exists.
  - Resume=1 in HALTED: PC <= PC + PC_STEP, next state RUN, StayHalted falls after the edge.
  - Resume ignored outside HALTED.
  - Halt and Resume asserted together: Halt wins.
- FETCH_RESUME_EN undefined:
  - Resume port absent.
  - HALTED is terminal until reset.

## Structure
- Shared pipeline package:
  - fetch state encoding: FS_RUN=2'd0, FS_STALL=2'd1, FS_HALTED=2'd2
  - WORD_W=16
  - NOP_INSTR=16'h0000
- Sub-module pc_reg:
  - PC register with load/hold/increment controls and async active-low reset.
  - Remaining logic (FSM, OldInstruction, FlushOut) stays in fetch_stage.

## Test plan
- Reset then 4 free-running cycles, RESET_PC=0 -> ImemAddr 0000, 0002, 0004, 0006; PCOUT always ImemAddr+2; StayHalted=0.
- At PC=0006, BranchTaken=1, BranchTarget=0040 for 1 cycle -> FlushOut=1 that cycle; next ImemAddr=0040, then 0042.
- StopPC=1 for 3 cycles at PC=0010 (mem[000E]=1234) -> ImemAddr stays 0010; OldInstruction=1234; after release, ImemAddr=0012.
- Halt=1 with BranchTaken=1 at PC=0020 -> FlushOut=0; StayHalted=1 from next cycle; PC stays 0020 for 10 cycles despite later branches.
- PC=FFFE, run one cycle -> ImemAddr=0000.
- rst low mid-STALL and mid-HALTED -> immediately ImemAddr=RESET_PC, OldInstruction=0000, StayHalted=0. With FETCH_RESUME_EN: Resume=1 in HALTED at 0020 -> ImemAddr=0022, StayHalted=0.
